float_unit_arbiter: RTL and testbench

FLOAT_UNIT_ARBITER -- requirements
Module: float_unit_arbiter

---
 rtl/float_unit_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_float_unit_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_unit_arbiter.sv
// float_unit_arbiter: shares one floating-point unit (adder or multiplier)
// among four requesters, with exactly one transaction in flight at a time.
// Each transaction runs: grant -> issue operands -> wait for the result ->
// return the result to the granted requester.
// Build option: define FLOAT_ARB_FIXED_PRIO_EN for fixed priority, where
// requester 0 is highest. Left undefined, the arbiter uses round-robin.
module float_unit_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    input  logic [N_REQ*DATA_W-1:0] i_REQ_A,
    input  logic [N_REQ*DATA_W-1:0] i_REQ_B,
    input  logic [N_REQ-1:0]        i_REQ_AB_STB,
    output logic [N_REQ-1:0]        o_REQ_AB_ACK,
    output logic [DATA_W-1:0]       o_REQ_Z,
    output logic [N_REQ-1:0]        o_REQ_Z_STB,
    input  logic [N_REQ-1:0]        i_REQ_Z_ACK,
    output logic [DATA_W-1:0]       o_U_A,
    output logic [DATA_W-1:0]       o_U_B,
    output logic                    o_U_AB_STB,
    input  logic                    i_U_AB_ACK,
    input  logic [DATA_W-1:0]       i_U_Z,
    input  logic                    i_U_Z_STB,
    output logic                    o_U_Z_ACK,
    output logic [1:0]              o_GRANT,
    output logic                    o_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_Z = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [N_REQ-1:0]    r_ab_ack;
    logic [DATA_W-1:0]   r_req_z;
    logic [N_REQ-1:0]    r_z_stb;
    logic [DATA_W-1:0]   r_u_a;
    logic [DATA_W-1:0]   r_u_b;
    logic                r_u_ab_stb;
    logic                r_u_z_ack;
    logic [1:0]          r_grant;

    logic                w_any;
    logic [1:0]          w_win;
    logic [N_REQ-1:0]    w_win_oh;
    logic [N_REQ-1:0]    w_grant_oh;
    logic [DATA_W-1:0]   w_a_sel;
    logic [DATA_W-1:0]   w_b_sel;
    logic                w_z_ack;

`ifdef FLOAT_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest-numbered active requester wins.
    always_comb begin
        w_win = 2'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_REQ_AB_STB[i]) w_win = 2'(i);
        end
    end
`else
    logic [1:0]          r_last;

    // Round-robin: search from r_last+1 and wrap; the loop runs downward so
    // the requester closest after r_last overwrites the others.
    always_comb begin
        w_win = 2'd0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (i_REQ_AB_STB[r_last + 2'(i)]) w_win = r_last + 2'(i);
        end
    end

    // Remember the last served requester once its result has been taken.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_last <= 2'd3;
        end else if (r_state == ST_RETURN && w_z_ack) begin
            r_last <= r_grant;
        end
    end
`endif

    // Winner/grant one-hots and the winner's operand mux.
    always_comb begin
        w_any      = |i_REQ_AB_STB;
        w_win_oh   = '0;
        w_grant_oh = '0;
        w_a_sel    = '0;
        w_b_sel    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_win_oh[k]   = (w_win == 2'(k));
            w_grant_oh[k] = (r_grant == 2'(k));
            if (w_win == 2'(k)) begin
                w_a_sel = i_REQ_A[k*DATA_W +: DATA_W];
                w_b_sel = i_REQ_B[k*DATA_W +: DATA_W];
            end
        end
        // Result ACKs from requesters other than the granted one are ignored.
        w_z_ack = |(i_REQ_Z_ACK & w_grant_oh);
    end

    // State register.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; each handshake input is only looked at in its own state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any)                    w_state_nxt = ST_ISSUE;
            ST_ISSUE:  if (r_u_ab_stb && i_U_AB_ACK) w_state_nxt = ST_WAIT_Z;
            ST_WAIT_Z: if (i_U_Z_STB)                w_state_nxt = ST_RETURN;
            ST_RETURN: if (w_z_ack)                  w_state_nxt = ST_IDLE;
            default:                                 w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs: operand latch, handshake strobes and the result hold.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_ab_ack   <= '0;
            r_req_z    <= '0;
            r_z_stb    <= '0;
            r_u_a      <= '0;
            r_u_b      <= '0;
            r_u_ab_stb <= 1'b0;
            r_u_z_ack  <= 1'b0;
            r_grant    <= 2'd0;
        end else begin
            r_ab_ack  <= '0;
            r_u_z_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_u_a      <= w_a_sel;
                        r_u_b      <= w_b_sel;
                        r_ab_ack   <= w_win_oh;
                        r_u_ab_stb <= 1'b1;
                        r_grant    <= w_win;
                    end
                end
                ST_ISSUE: begin
                    if (i_U_AB_ACK) r_u_ab_stb <= 1'b0;
                end
                ST_WAIT_Z: begin
                    if (i_U_Z_STB) begin
                        r_req_z   <= i_U_Z;
                        r_u_z_ack <= 1'b1;
                        r_z_stb   <= w_grant_oh;
                    end
                end
                ST_RETURN: begin
                    if (w_z_ack) r_z_stb <= '0;
                end
                default: ;
            endcase
        end
    end

    // Busy flag derived from the state.
    always_comb begin
        o_BUSY = (r_state != ST_IDLE);
    end

    assign o_REQ_AB_ACK = r_ab_ack;
    assign o_REQ_Z      = r_req_z;
    assign o_REQ_Z_STB  = r_z_stb;
    assign o_U_A        = r_u_a;
    assign o_U_B        = r_u_b;
    assign o_U_AB_STB   = r_u_ab_stb;
    assign o_U_Z_ACK    = r_u_z_ack;
    assign o_GRANT      = r_grant;

endmodule

// File: tb/tb_float_unit_arbiter.sv
// Testbench for float_unit_arbiter: table-driven transactions, hand-written
// reset/stray-input sequences and randomized transactions checked against a
// rotating-priority-list model.
module tb_float_unit_arbiter;

    logic          i_CLK = 1'b0;
    logic          i_RSTN;
    logic [127:0]  i_REQ_A;
    logic [127:0]  i_REQ_B;
    logic [3:0]    i_REQ_AB_STB;
    logic [3:0]    o_REQ_AB_ACK;
    logic [31:0]   o_REQ_Z;
    logic [3:0]    o_REQ_Z_STB;
    logic [3:0]    i_REQ_Z_ACK;
    logic [31:0]   o_U_A;
    logic [31:0]   o_U_B;
    logic          o_U_AB_STB;
    logic          i_U_AB_ACK;
    logic [31:0]   i_U_Z;
    logic          i_U_Z_STB;
    logic          o_U_Z_ACK;
    logic [1:0]    o_GRANT;
    logic          o_BUSY;

    float_unit_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
        .i_CLK(i_CLK), .i_RSTN(i_RSTN),
        .i_REQ_A(i_REQ_A), .i_REQ_B(i_REQ_B), .i_REQ_AB_STB(i_REQ_AB_STB),
        .o_REQ_AB_ACK(o_REQ_AB_ACK), .o_REQ_Z(o_REQ_Z), .o_REQ_Z_STB(o_REQ_Z_STB),
        .i_REQ_Z_ACK(i_REQ_Z_ACK), .o_U_A(o_U_A), .o_U_B(o_U_B),
        .o_U_AB_STB(o_U_AB_STB), .i_U_AB_ACK(i_U_AB_ACK), .i_U_Z(i_U_Z),
        .i_U_Z_STB(i_U_Z_STB), .o_U_Z_ACK(o_U_Z_ACK), .o_GRANT(o_GRANT),
        .o_BUSY(o_BUSY)
    );

    always #5 i_CLK = ~i_CLK;

`ifdef FLOAT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic [3:0]        stb;
        logic [3:0][31:0]  a;
        logic [3:0][31:0]  b;
        logic [31:0]       z;
        int                ack_dly;
        int                z_dly;
        int                zack_dly;
        logic [1:0]        exp_rr;
        logic [1:0]        exp_fp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Priority list model: front of the queue is the highest priority.
    // Round-robin rotates the list so the last winner moves to the back.
    int prio_q[$];

    function automatic void model_reset();
        prio_q = {0, 1, 2, 3};
    endfunction

    function automatic logic [1:0] model_pick(logic [3:0] stb);
        foreach (prio_q[i]) begin
            if (stb[prio_q[i]]) return 2'(prio_q[i]);
        end
        return 2'd0;
    endfunction

    function automatic void model_grant(logic [1:0] g);
        if (!FIXED) begin
            while (prio_q[$] != int'(g)) prio_q.push_back(prio_q.pop_front());
        end
    endfunction

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ab_ack"}, o_REQ_AB_ACK, 0);
        check({tag, "_req_z"},  o_REQ_Z, 0);
        check({tag, "_z_stb"},  o_REQ_Z_STB, 0);
        check({tag, "_u_a"},    o_U_A, 0);
        check({tag, "_u_b"},    o_U_B, 0);
        check({tag, "_u_stb"},  o_U_AB_STB, 0);
        check({tag, "_u_zack"}, o_U_Z_ACK, 0);
        check({tag, "_grant"},  o_GRANT, 0);
        check({tag, "_busy"},   o_BUSY, 0);
    endtask

    // One full transaction with expected winner g, checked every cycle.
    task automatic run_txn(input vec_t t, input logic [1:0] g, input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        i_REQ_A = t.a;
        i_REQ_B = t.b;
        i_REQ_AB_STB = t.stb;
        tick();
        check({tag, "_ab_ack"}, o_REQ_AB_ACK, oh);
        check({tag, "_grant"},  o_GRANT, g);
        check({tag, "_u_stb"},  o_U_AB_STB, 1);
        check({tag, "_u_a"},    o_U_A, t.a[g]);
        check({tag, "_u_b"},    o_U_B, t.b[g]);
        check({tag, "_busy"},   o_BUSY, 1);
        i_REQ_AB_STB = t.stb & ~oh;
        // Unit stalls; a stray result strobe must be ignored here.
        for (int i = 0; i < t.ack_dly; i++) begin
            i_U_Z_STB = 1'b1;
            i_U_Z = $urandom;
            tick();
            check({tag, "_stall_u_stb"},  o_U_AB_STB, 1);
            check({tag, "_stall_u_a"},    o_U_A, t.a[g]);
            check({tag, "_stall_u_b"},    o_U_B, t.b[g]);
            check({tag, "_stall_ab_ack"}, o_REQ_AB_ACK, 0);
            check({tag, "_stall_z_stb"},  o_REQ_Z_STB, 0);
        end
        i_U_Z_STB = 1'b0;
        i_U_AB_ACK = 1'b1;
        tick();
        check({tag, "_issued_u_stb"}, o_U_AB_STB, 0);
        check({tag, "_issued_ab_ack"}, o_REQ_AB_ACK, 0);
        // Waiting for the result; a stray operand ACK must be ignored.
        for (int i = 0; i < t.z_dly; i++) begin
            tick();
            check({tag, "_wait_z_stb"}, o_REQ_Z_STB, 0);
            check({tag, "_wait_u_stb"}, o_U_AB_STB, 0);
        end
        i_U_AB_ACK = 1'b0;
        i_U_Z = t.z;
        i_U_Z_STB = 1'b1;
        tick();
        i_U_Z_STB = 1'b0;
        i_U_Z = ~t.z;
        check({tag, "_z_stb"},  o_REQ_Z_STB, oh);
        check({tag, "_z"},      o_REQ_Z, t.z);
        check({tag, "_u_zack"}, o_U_Z_ACK, 1);
        // Requester delays its ACK; stray ACKs from the others are ignored.
        for (int i = 0; i < t.zack_dly; i++) begin
            i_REQ_Z_ACK = ~oh;
            tick();
            check({tag, "_hold_z_stb"},  o_REQ_Z_STB, oh);
            check({tag, "_hold_z"},      o_REQ_Z, t.z);
            check({tag, "_hold_u_zack"}, o_U_Z_ACK, 0);
            check({tag, "_hold_ab_ack"}, o_REQ_AB_ACK, 0);
            check({tag, "_hold_grant"},  o_GRANT, g);
        end
        i_REQ_Z_ACK = oh;
        tick();
        i_REQ_Z_ACK = 4'b0000;
        check({tag, "_done_z_stb"}, o_REQ_Z_STB, 0);
        check({tag, "_done_busy"},  o_BUSY, 0);
        i_REQ_AB_STB = 4'b0000;
    endtask

    function automatic vec_t mk(logic [3:0] stb, int ad, int zd, int zkd,
                                logic [1:0] rr, logic [1:0] fp);
        vec_t v;
        v.stb = stb;
        for (int k = 0; k < 4; k++) begin
            v.a[k] = $urandom;
            v.b[k] = $urandom;
        end
        v.z = $urandom;
        v.ack_dly = ad;
        v.z_dly = zd;
        v.zack_dly = zkd;
        v.exp_rr = rr;
        v.exp_fp = fp;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        logic [1:0] g;
        vec_t v;

        // Four requesters held on together, then assorted patterns.
        tbl[0]  = mk(4'b1111, 0, 1, 0, 2'd0, 2'd0);
        tbl[1]  = mk(4'b1111, 1, 0, 1, 2'd1, 2'd0);
        tbl[2]  = mk(4'b1111, 0, 2, 0, 2'd2, 2'd0);
        tbl[3]  = mk(4'b1111, 2, 1, 1, 2'd3, 2'd0);
        tbl[4]  = mk(4'b1111, 0, 0, 0, 2'd0, 2'd0);
        tbl[5]  = mk(4'b0010, 0, 5, 3, 2'd1, 2'd1);
        tbl[5].a[1] = 32'h3f80_0000;
        tbl[5].b[1] = 32'h4000_0000;
        tbl[5].z    = 32'h4040_0000;
        tbl[6]  = mk(4'b1100, 1, 1, 0, 2'd2, 2'd2);
        tbl[7]  = mk(4'b1001, 0, 2, 2, 2'd3, 2'd0);
        tbl[8]  = mk(4'b0100, 10, 1, 0, 2'd2, 2'd2);
        tbl[9]  = mk(4'b0101, 0, 0, 1, 2'd0, 2'd0);
        tbl[10] = mk(4'b0110, 0, 1, 20, 2'd1, 2'd1);
        tbl[11] = mk(4'b0100, 0, 1, 0, 2'd2, 2'd2);

        i_RSTN = 1'b0;
        i_REQ_A = '0;
        i_REQ_B = '0;
        i_REQ_AB_STB = 4'b0000;
        i_REQ_Z_ACK = 4'b0000;
        i_U_AB_ACK = 1'b0;
        i_U_Z = '0;
        i_U_Z_STB = 1'b0;
        model_reset();

        // Reset state, even with requests pending.
        i_REQ_AB_STB = 4'b1111;
        tick();
        tick();
        check_all_zero("reset");
        i_REQ_AB_STB = 4'b0000;
        i_RSTN = 1'b1;

        // Table of transactions.
        for (int r = 0; r < 12; r++) begin
            g = FIXED ? tbl[r].exp_fp : tbl[r].exp_rr;
            run_txn(tbl[r], g, $sformatf("tbl%0d", r));
            model_grant(g);
        end

        // Stray unit strobes while idle change nothing.
        i_U_Z_STB = 1'b1;
        i_U_AB_ACK = 1'b1;
        i_REQ_Z_ACK = 4'b1111;
        tick();
        tick();
        i_U_Z_STB = 1'b0;
        i_U_AB_ACK = 1'b0;
        i_REQ_Z_ACK = 4'b0000;
        check("idle_stray_busy",  o_BUSY, 0);
        check("idle_stray_z_stb", o_REQ_Z_STB, 0);
        check("idle_stray_u_zack", o_U_Z_ACK, 0);
        check("idle_stray_u_stb", o_U_AB_STB, 0);
        check("idle_stray_ab_ack", o_REQ_AB_ACK, 0);

        // Reset while waiting for the unit result aborts the transaction.
        v = mk(4'b1000, 0, 0, 0, 2'd3, 2'd3);
        i_REQ_A = v.a;
        i_REQ_B = v.b;
        i_REQ_AB_STB = 4'b1000;
        tick();
        check("abort_grant", o_GRANT, 3);
        i_REQ_AB_STB = 4'b0000;
        i_U_AB_ACK = 1'b1;
        tick();
        i_U_AB_ACK = 1'b0;
        check("abort_wait_busy", o_BUSY, 1);
        i_RSTN = 1'b0;
        #1;
        check_all_zero("abort_async");
        i_U_Z = 32'hdead_beef;
        i_U_Z_STB = 1'b1;
        tick();
        i_U_Z_STB = 1'b0;
        check_all_zero("abort_held");
        i_RSTN = 1'b1;
        model_reset();
        v = mk(4'b1111, 0, 1, 0, 2'd0, 2'd0);
        g = model_pick(v.stb);
        run_txn(v, g, "post_reset");
        check("post_reset_winner0", g, 0);
        model_grant(g);

        // Randomized transactions against the model.
        for (int r = 0; r < 40; r++) begin
            v = mk(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 2'd0, 2'd0);
            g = model_pick(v.stb);
            run_txn(v, g, $sformatf("rnd%0d", r));
            model_grant(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
